// File: rtl/dma_copy.sv
`default_nettype none
// ============================================================================
// Module      : dma_copy
// Description : Memory-to-memory word copy engine. A CPU-facing register
//               slave holds SRC/DST/LEN/CTRL/STATUS; a valid/ready initiator
//               port performs one read beat followed by one write beat per
//               32-bit word, then reports completion via STATUS and irq.
// Revision    : 1.0 - initial release
// ============================================================================
module dma_copy #(
    parameter int LEN_W     = 16,
    parameter int ADDR_STEP = 4
) (
    input  logic        clk,
    input  logic        reset_n,
    // register slave port
    input  logic        select,
    input  logic [3:0]  wstrb,
    input  logic [4:0]  addr,
    input  logic [31:0] data_i,
    output logic        ready,
    output logic [31:0] data_o,
    output logic        irq,
    // memory initiator port
    output logic        mem_valid,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_wstrb,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ready
);

    localparam logic [4:0]  A_CTRL   = 5'h00;
    localparam logic [4:0]  A_STATUS = 5'h04;
    localparam logic [4:0]  A_SRC    = 5'h08;
    localparam logic [4:0]  A_DST    = 5'h0C;
    localparam logic [4:0]  A_LEN    = 5'h10;
    localparam logic [31:0] STEP     = 32'(ADDR_STEP);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RD   = 2'd1,
        WR   = 2'd2,
        FIN  = 2'd3
    } state_t;

    state_t             state;
    logic               irq_en;
    logic               done;
    logic               aborted;
    logic               abort_pend;
    logic [31:0]        src;
    logic [31:0]        dst;
    logic [LEN_W-1:0]   len;

    logic               accept;
    logic               wr_en;
    logic               ctrl_wr;
    logic               start_req;
    logic               abort_req;
    logic               abort_now;
    logic               busy;
    logic [LEN_W-1:0]   len_next;
    logic [31:0]        rd_val;

    // A slave access is taken once per select; ready blocks re-acceptance.
    assign accept    = select && !ready;
    assign wr_en     = accept && (wstrb != 4'h0);
    assign ctrl_wr   = wr_en && (addr == A_CTRL);
    assign start_req = ctrl_wr && data_i[0];
    assign abort_req = ctrl_wr && data_i[2];
    // An abort arriving on the very edge a write completes still stops the copy.
    assign abort_now = abort_pend || abort_req;
    assign busy      = (state == RD) || (state == WR);
    assign len_next  = len - LEN_W'(1);

    // Register read mux; SRC/DST/LEN always show their live values.
    always_comb begin
        rd_val = 32'h0;
        case (addr)
            A_CTRL:   rd_val = {30'h0, irq_en, 1'b0};
            A_STATUS: rd_val = {29'h0, aborted, done, busy};
            A_SRC:    rd_val = src;
            A_DST:    rd_val = dst;
            A_LEN:    rd_val = 32'(len);
            default:  rd_val = 32'h0;
        endcase
    end

    // Slave handshake: one-cycle ready pulse, read data captured with it.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ready  <= 1'b0;
            data_o <= 32'h0;
        end else begin
            ready <= accept;
            if (accept && (wstrb == 4'h0)) begin
                data_o <= rd_val;
            end
        end
    end

    // Configuration registers and the copy FSM share SRC/DST/LEN, so they
    // live in one sequential block with registered initiator outputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= IDLE;
            irq_en     <= 1'b0;
            done       <= 1'b0;
            aborted    <= 1'b0;
            abort_pend <= 1'b0;
            src        <= 32'h0;
            dst        <= 32'h0;
            len        <= '0;
            irq        <= 1'b0;
            mem_valid  <= 1'b0;
            mem_addr   <= 32'h0;
            mem_wdata  <= 32'h0;
            mem_wstrb  <= 4'h0;
        end else begin
            irq <= 1'b0;

            if (ctrl_wr) begin
                irq_en <= data_i[1];
            end

            case (state)
                IDLE: begin
                    if (wr_en) begin
                        case (addr)
                            A_SRC:   src <= {data_i[31:2], 2'b00};
                            A_DST:   dst <= {data_i[31:2], 2'b00};
                            A_LEN:   len <= data_i[LEN_W-1:0];
                            default: ;
                        endcase
                    end
                    // ABORT alongside START is dropped: abort_pend is cleared.
                    if (start_req) begin
                        done       <= 1'b0;
                        aborted    <= 1'b0;
                        abort_pend <= 1'b0;
                        if (len != '0) begin
                            state     <= RD;
                            mem_valid <= 1'b1;
                            mem_addr  <= src;
                            mem_wstrb <= 4'h0;
                        end else begin
                            // Empty transfer: finish without touching the bus.
                            state <= FIN;
                            done  <= 1'b1;
                            irq   <= data_i[1];
                        end
                    end
                end

                RD: begin
                    if (abort_req) begin
                        abort_pend <= 1'b1;
                    end
                    if (mem_ready) begin
                        mem_wdata <= mem_rdata;
                        src       <= src + STEP;
                        mem_addr  <= dst;
                        mem_wstrb <= 4'hF;
                        state     <= WR;
                    end
                end

                WR: begin
                    if (abort_req) begin
                        abort_pend <= 1'b1;
                    end
                    if (mem_ready) begin
                        dst <= dst + STEP;
                        len <= len_next;
                        if ((len_next == '0) || abort_now) begin
                            state     <= FIN;
                            mem_valid <= 1'b0;
                            mem_wstrb <= 4'h0;
                            done      <= !abort_now;
                            aborted   <= abort_now;
                            irq       <= irq_en;
                        end else begin
                            state     <= RD;
                            mem_addr  <= src;
                            mem_wstrb <= 4'h0;
                        end
                    end
                end

                FIN: begin
                    abort_pend <= 1'b0;
                    state      <= IDLE;
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_dma_copy.sv
`default_nettype none
// ============================================================================
// Module      : tb_dma_copy
// Description : Self-checking bench for dma_copy with a wait-state memory
//               responder and a word-list reference model of each copy.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dma_copy;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        select;
    logic [3:0]  wstrb;
    logic [4:0]  addr;
    logic [31:0] data_i;
    logic        ready;
    logic [31:0] data_o;
    logic        irq;
    logic        mem_valid;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
    logic [31:0] mem_rdata;
    logic        mem_ready;

    int total = 0;
    int bad   = 0;

    dma_copy #(.LEN_W(16), .ADDR_STEP(4)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .select    (select),
        .wstrb     (wstrb),
        .addr      (addr),
        .data_i    (data_i),
        .ready     (ready),
        .data_o    (data_o),
        .irq       (irq),
        .mem_valid (mem_valid),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_wstrb (mem_wstrb),
        .mem_rdata (mem_rdata),
        .mem_ready (mem_ready)
    );

    always #5 clk = ~clk;

    // ---------------- memory responder ----------------
    typedef struct {
        logic [31:0] a;
        logic [3:0]  s;
        logic [31:0] d;
        int          cyc;
    } beat_t;

    logic [31:0] mem [logic [31:0]];
    beat_t       beats[$];
    int          wait_states = 0;
    int          wcnt = 0;
    int          cyc = 0;
    int          irq_count = 0;
    int          irq_cyc = 0;
    int          valid_seen = 0;
    int          stab_err = 0;
    logic        waiting = 1'b0;
    logic [31:0] h_addr, h_wdata;
    logic [3:0]  h_wstrb;

    always @(negedge clk) begin
        if (irq === 1'b1) begin
            irq_count++;
            irq_cyc = cyc;
        end
        if (reset_n === 1'b1 && mem_valid === 1'b1) begin
            valid_seen++;
            if (waiting && (mem_addr !== h_addr || mem_wdata !== h_wdata || mem_wstrb !== h_wstrb))
                stab_err++;
            h_addr  = mem_addr;
            h_wdata = mem_wdata;
            h_wstrb = mem_wstrb;
            mem_rdata = mem.exists(mem_addr) ? mem[mem_addr] : 32'hDEAD_0000;
            if (wcnt >= wait_states) begin
                mem_ready = 1'b1;
                waiting   = 1'b0;
            end else begin
                mem_ready = 1'b0;
                waiting   = 1'b1;
                wcnt++;
            end
        end else begin
            mem_ready = 1'b0;
            waiting   = 1'b0;
            wcnt      = 0;
        end
    end

    always @(posedge clk) begin
        if (reset_n === 1'b1 && mem_valid === 1'b1 && mem_ready === 1'b1) begin
            beats.push_back('{a: mem_addr, s: mem_wstrb,
                              d: (mem_wstrb == 4'hF) ? mem_wdata : mem_rdata, cyc: cyc});
            if (mem_wstrb == 4'hF) mem[mem_addr] = mem_wdata;
            wcnt = 0;
        end
        cyc++;
    end

    // ---------------- CPU access tasks ----------------
    task automatic reg_write(input logic [4:0] a, input logic [31:0] v);
        @(negedge clk);
        select = 1'b1; wstrb = 4'hF; addr = a; data_i = v;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (ready) break;
        end
        if (!ready) begin
            total++; bad++;
            $display("FAIL wr_timeout addr=%h ready=%b required 1", a, ready);
        end
        select = 1'b0; wstrb = 4'h0;
    endtask

    task automatic reg_read(input logic [4:0] a, output logic [31:0] v);
        @(negedge clk);
        select = 1'b1; wstrb = 4'h0; addr = a;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (ready) break;
        end
        if (!ready) begin
            total++; bad++;
            $display("FAIL rd_timeout addr=%h ready=%b required 1", a, ready);
        end
        v = data_o;
        select = 1'b0;
    endtask

    task automatic wait_idle(output logic [31:0] st);
        int k;
        for (k = 0; k < 400; k++) begin
            reg_read(5'h04, st);
            if (st[0] == 1'b0 && st[2:1] != 2'b00) break;
        end
        if (k == 400) begin
            total++; bad++;
            $display("FAIL idle_timeout status=%h required done or aborted", st);
        end
    endtask

    // Full copy with reference model: expected beat list, memory image, regs.
    task automatic run_copy(input logic [31:0] s, input logic [31:0] d, input int n,
                            input logic ie, input int ws, input logic fixed,
                            input string nm);
        logic [31:0] exp_d[$];
        logic [31:0] v, st;
        for (int i = 0; i < n; i++) begin
            exp_d.push_back(fixed ? 32'hA + 32'(i) : $urandom);
            mem[s + 32'(4*i)] = exp_d[i];
        end
        beats.delete();
        irq_count   = 0;
        valid_seen  = 0;
        stab_err    = 0;
        wait_states = ws;
        reg_write(5'h08, s);
        reg_write(5'h0C, d);
        reg_write(5'h10, 32'(n));
        reg_write(5'h00, ie ? 32'h3 : 32'h1);
        wait_idle(st);
        repeat (3) @(negedge clk);

        total++;
        if (beats.size() != 2*n) begin
            bad++;
            $display("FAIL %s beat_count got=%0d required=%0d", nm, beats.size(), 2*n);
        end else begin
            for (int i = 0; i < n; i++) begin
                total++;
                if (beats[2*i].a !== s + 32'(4*i) || beats[2*i].s !== 4'h0) begin
                    bad++;
                    $display("FAIL %s rd_beat%0d addr=%h strb=%h required addr=%h strb=0",
                             nm, i, beats[2*i].a, beats[2*i].s, s + 32'(4*i));
                end
                total++;
                if (beats[2*i+1].a !== d + 32'(4*i) || beats[2*i+1].s !== 4'hF ||
                    beats[2*i+1].d !== exp_d[i]) begin
                    bad++;
                    $display("FAIL %s wr_beat%0d addr=%h data=%h required addr=%h data=%h",
                             nm, i, beats[2*i+1].a, beats[2*i+1].d, d + 32'(4*i), exp_d[i]);
                end
            end
        end
        total++;
        if (st !== 32'h2) begin
            bad++; $display("FAIL %s status got=%h required=%h", nm, st, 32'h2);
        end
        reg_read(5'h10, v);
        total++;
        if (v !== 32'h0) begin
            bad++; $display("FAIL %s len got=%h required=0", nm, v);
        end
        reg_read(5'h08, v);
        total++;
        if (v !== s + 32'(4*n)) begin
            bad++; $display("FAIL %s src got=%h required=%h", nm, v, s + 32'(4*n));
        end
        reg_read(5'h0C, v);
        total++;
        if (v !== d + 32'(4*n)) begin
            bad++; $display("FAIL %s dst got=%h required=%h", nm, v, d + 32'(4*n));
        end
        total++;
        if (irq_count != (ie ? 1 : 0)) begin
            bad++; $display("FAIL %s irq_count got=%0d required=%0d", nm, irq_count, ie ? 1 : 0);
        end
        if (ie && n > 0 && beats.size() == 2*n) begin
            total++;
            if (irq_cyc != beats[2*n-1].cyc + 1) begin
                bad++;
                $display("FAIL %s irq_cycle got=%0d required=%0d", nm, irq_cyc, beats[2*n-1].cyc + 1);
            end
        end
        total++;
        if (stab_err != 0) begin
            bad++; $display("FAIL %s stability_errors got=%0d required=0", nm, stab_err);
        end
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        logic [31:0] v;
        total++;
        if (mem_valid !== 1'b0 || ready !== 1'b0 || irq !== 1'b0 || data_o !== 32'h0 ||
            mem_addr !== 32'h0 || mem_wdata !== 32'h0 || mem_wstrb !== 4'h0) begin
            bad++;
            $display("FAIL reset_outputs valid=%b ready=%b irq=%b data_o=%h addr=%h required all 0",
                     mem_valid, ready, irq, data_o, mem_addr);
        end
        @(negedge clk);
        reset_n = 1'b1;
        for (int r = 0; r <= 16; r += 4) begin
            reg_read(5'(r), v);
            total++;
            if (v !== 32'h0) begin
                bad++; $display("FAIL reset_reg%0h got=%h required=0", r, v);
            end
        end
    endtask

    task automatic test_basic();
        logic [31:0] v;
        run_copy(32'h100, 32'h200, 3, 1'b0, 0, 1'b1, "basic");
        total++;
        if (beats.size() != 6) begin
            bad++; $display("FAIL basic_six_beats got=%0d required=6", beats.size());
        end
        // ABORT while idle must leave STATUS untouched.
        reg_write(5'h00, 32'h4);
        reg_read(5'h04, v);
        total++;
        if (v !== 32'h2) begin
            bad++; $display("FAIL abort_idle status got=%h required=2", v);
        end
    endtask

    task automatic test_wait_irq();
        logic [31:0] v;
        run_copy(32'h100, 32'h200, 3, 1'b1, 3, 1'b1, "wait_irq");
        reg_read(5'h00, v);
        total++;
        if (v !== 32'h2) begin
            bad++; $display("FAIL ctrl_readback got=%h required=2", v);
        end
    endtask

    task automatic test_len_zero();
        run_copy(32'h800, 32'h900, 0, 1'b0, 0, 1'b0, "len0_noirq");
        total++;
        if (valid_seen != 0) begin
            bad++; $display("FAIL len0_valid got=%0d required=0", valid_seen);
        end
        run_copy(32'h800, 32'h900, 0, 1'b1, 0, 1'b0, "len0_irq");
        total++;
        if (valid_seen != 0) begin
            bad++; $display("FAIL len0_irq_valid got=%0d required=0", valid_seen);
        end
    endtask

    task automatic test_random();
        for (int k = 0; k < 4; k++) begin
            logic [31:0] s;
            s = 32'h0001_0000 + 32'(k) * 32'h1000;
            run_copy(s, s + 32'h800, $urandom_range(1, 8), 1'($urandom_range(0, 1)),
                     $urandom_range(0, 2), 1'b0, "random");
        end
    endtask

    task automatic test_abort();
        logic [31:0] v, st;
        logic [31:0] s, d;
        logic [31:0] exp_d[10];
        int k;
        s = 32'h3000; d = 32'h4000;
        for (int i = 0; i < 10; i++) begin
            exp_d[i] = $urandom;
            mem[s + 32'(4*i)] = exp_d[i];
        end
        beats.delete();
        wait_states = 3;
        reg_write(5'h08, s);
        reg_write(5'h0C, d);
        reg_write(5'h10, 32'd10);
        reg_write(5'h00, 32'h1);
        for (k = 0; k < 500; k++) begin
            @(negedge clk);
            if (beats.size() == 8 && mem_valid && mem_wstrb == 4'h0) break;
        end
        total++;
        if (k == 500) begin
            bad++; $display("FAIL abort_reach_word4 beats=%0d required 8", beats.size());
        end
        reg_write(5'h00, 32'h4);
        wait_idle(st);
        total++;
        if (st !== 32'h4) begin
            bad++; $display("FAIL abort_status got=%h required=4", st);
        end
        total++;
        if (beats.size() != 10) begin
            bad++; $display("FAIL abort_beats got=%0d required=10", beats.size());
        end
        for (int i = 0; i < 5; i++) begin
            total++;
            if (!mem.exists(d + 32'(4*i)) || mem[d + 32'(4*i)] !== exp_d[i]) begin
                bad++; $display("FAIL abort_word%0d not copied, required %h", i, exp_d[i]);
            end
        end
        total++;
        if (mem.exists(d + 32'd20)) begin
            bad++; $display("FAIL abort_word5 written=%h required none", mem[d + 32'd20]);
        end
        reg_read(5'h10, v);
        total++;
        if (v !== 32'd5) begin
            bad++; $display("FAIL abort_len got=%h required=5", v);
        end
        reg_read(5'h08, v);
        total++;
        if (v !== s + 32'd20) begin
            bad++; $display("FAIL abort_src got=%h required=%h", v, s + 32'd20);
        end
    endtask

    task automatic test_wrap();
        logic [31:0] v, st;
        for (int i = 0; i < 4; i++) mem[32'h5000 + 32'(4*i)] = $urandom;
        wait_states = 3;
        reg_write(5'h08, 32'h5000);
        reg_write(5'h0C, 32'h6000);
        reg_write(5'h10, 32'd4);
        reg_write(5'h00, 32'h1);
        reg_write(5'h08, 32'hFFFF_FFFC);
        wait_idle(st);
        reg_read(5'h08, v);
        total++;
        if (v !== 32'h5010) begin
            bad++; $display("FAIL busy_src_write got=%h required=%h", v, 32'h5010);
        end
        run_copy(32'hFFFF_FFFC, 32'h7000, 2, 1'b0, 0, 1'b0, "wrap");
        total++;
        if (beats.size() < 3 || beats[2].a !== 32'h0) begin
            bad++; $display("FAIL wrap_second_read got=%h required=0", beats.size() >= 3 ? beats[2].a : 32'hX);
        end
    endtask

    task automatic test_reset_mid();
        logic [31:0] v;
        int k;
        for (int i = 0; i < 4; i++) mem[32'h8000 + 32'(4*i)] = $urandom;
        wait_states = 3;
        reg_write(5'h08, 32'h8000);
        reg_write(5'h0C, 32'h9000);
        reg_write(5'h10, 32'd4);
        reg_write(5'h00, 32'h3);
        for (k = 0; k < 200; k++) begin
            @(negedge clk);
            if (mem_valid && mem_wstrb == 4'hF) break;
        end
        total++;
        if (k == 200) begin
            bad++; $display("FAIL reset_mid_reach_wr valid=%b required 1", mem_valid);
        end
        #2 reset_n = 1'b0;
        #1;
        total++;
        if (mem_valid !== 1'b0 || mem_wstrb !== 4'h0) begin
            bad++; $display("FAIL reset_mid_valid got=%b required=0", mem_valid);
        end
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        for (int r = 0; r <= 16; r += 4) begin
            reg_read(5'(r), v);
            total++;
            if (v !== 32'h0) begin
                bad++; $display("FAIL reset_mid_reg%0h got=%h required=0", r, v);
            end
        end
        run_copy(32'hA000, 32'hB000, 3, 1'b1, 1, 1'b0, "after_reset");
    endtask

    initial begin
        reset_n   = 1'b0;
        select    = 1'b0;
        wstrb     = 4'h0;
        addr      = 5'h0;
        data_i    = 32'h0;
        mem_ready = 1'b0;
        mem_rdata = 32'h0;
        repeat (3) @(negedge clk);
        test_reset();
        test_basic();
        test_wait_irq();
        test_len_zero();
        test_random();
        test_abort();
        test_wrap();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout time=%0t required completion", $time);
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire

// File: doc/dma_copy.md
Name: dma_copy

Overview:
- Memory-to-memory word copy engine.
- The CPU configures it through a small register slave port, using the same select/wstrb/addr/ready protocol as the other peripherals.
- The engine then acts as a bus initiator on a native valid/ready memory port that feeds the system interconnect.
- It copies LEN 32-bit words from SRC to DST, one read followed by one write per word, and flags completion with a status bit and an optional irq pulse.

Parameters:
- LEN_W, 16, width of the LEN register / word counter (max transfer 2^LEN_W-1 words).
- ADDR_STEP, 4, byte increment applied to SRC/DST after each word.

Ports:
- clk  in  1  system clock
- reset_n  in  1  reset
- select  in  1  slave access request from the CPU
- wstrb  in  4  slave write strobes; 0 = read
- addr  in  5  slave byte address (registers at 0x0-0x10)
- data_i  in  32  slave write data
- ready  out  1  slave access complete (1-cycle pulse)
- data_o  out  32  slave read data
- irq  out  1  completion interrupt (1-cycle pulse)
- mem_valid  out  1  initiator request
- mem_addr  out  32  initiator byte address, word aligned
- mem_wdata  out  32  initiator write data
- mem_wstrb  out  4  initiator strobes; 0 = read, 4'hF = write
- mem_rdata  in  32  initiator read data, valid when mem_ready=1
- mem_ready  in  1  responder completes the beat

Behaviour:
- Reset: reset_n, asynchronous, active-low; clock clk.
  - All registers, ready, data_o, irq, mem_valid, mem_addr, mem_wdata and mem_wstrb are 0.
  - FSM resets to IDLE.
- Slave port:
  - A cycle with select=1 and ready=0 is accepted. ready=1 is driven on the following cycle for exactly one cycle; the CPU drops select on ready.
  - Reads update data_o in the same cycle that ready rises.
  - Unmapped addresses read 0 and ignore writes.
  - Writes use full-word semantics regardless of the individual wstrb bits.
- Register map:
  - 0x0 CTRL RW: bit0 START (write-1, self-clears, reads 0); bit1 IRQ_EN; bit2 ABORT (write-1, self-clears).
  - 0x4 STATUS R: bit0 BUSY; bit1 DONE (sticky); bit2 ABORTED (sticky). DONE and ABORTED are cleared by START.
  - 0x8 SRC RW, 0xC DST RW: the low 2 bits are forced to 0 on write.
  - 0x10 LEN RW: LEN_W bits, zero-extended on read.
  - While BUSY, SRC/DST/LEN read back their live incrementing/decrementing values, and writes to them are ignored.
- FSM states: IDLE, RD, WR, FIN.
  - IDLE -> START with LEN!=0: go to RD, BUSY=1, mem_valid=1, mem_addr=SRC, mem_wstrb=0.
  - IDLE -> START with LEN==0: go to FIN directly; no bus traffic.
  - RD, mem_ready=1: capture mem_rdata into mem_wdata; SRC += ADDR_STEP; go to WR with mem_addr=DST, mem_wstrb=4'hF, mem_valid held at 1.
  - WR, mem_ready=1: DST += ADDR_STEP; LEN -= 1. If the new LEN==0, or an abort is pending, go to FIN with mem_valid=0; otherwise go to RD.
  - FIN (one cycle): BUSY=0. DONE=1 if not aborted, else ABORTED=1. irq=1 for this one cycle if IRQ_EN. Then go to IDLE.
- Initiator protocol:
  - mem_valid, mem_addr, mem_wdata and mem_wstrb stay stable while mem_valid=1 and mem_ready=0.
  - The beat completes on the edge where both are 1.
  - No combinational path from mem_ready to mem_valid; back-to-back beats are allowed, so mem_valid may stay high across RD->WR.
  - A zero-wait responder (mem_ready tied 1) gives 2 cycles per word.
- Abort:
  - ABORT while BUSY sets a pending flag.
  - A pending abort never drops mem_valid mid-beat. If raised during RD, the read completes and its write is still performed; the engine stops after that WR.
  - ABORT while IDLE is ignored.
- START while BUSY is ignored.
- START and ABORT written together while IDLE: START wins and ABORT is ignored.
- SRC/DST wrap modulo 2^32; no error is flagged.
- reset_n asserted mid-transfer: immediate return to reset values, mem_valid=0 asynchronously.

Test Plan:
- SRC=0x100, DST=0x200, LEN=3, zero-wait memory model preloaded with 0xA,0xB,0xC, START -> writes 0xA,0xB,0xC to 0x200/0x204/0x208; STATUS=0x2; LEN reads 0; SRC=0x10C, DST=0x20C; 6 mem beats total.
- Same copy with IRQ_EN=1 and a responder adding 3 wait states per beat -> mem_addr/mem_wdata stable during waits; exactly one irq pulse, in the FIN cycle.
- LEN=0, START -> no mem_valid ever asserted; DONE=1 within 2 cycles; irq only if IRQ_EN.
- LEN=10, ABORT written while word 4 is in RD -> word 4 is still written; exactly 5 words copied; STATUS=0x4; LEN reads 5.
- Write SRC=0xFFFF_FFFC while BUSY -> ignored; separately, a copy from SRC=0xFFFF_FFFC with LEN=2 -> second read at address 0x0.
- Assert reset_n low during a WR beat -> mem_valid=0 immediately; all registers read 0 after release; a new START works normally.
